// File: rtl/sram_block_lanes.sv
// Simple dual-port on-chip buffer with per-lane write enables, selectable
// read-during-write result, 1- or 2-cycle read latency and a memory-clear sequencer.
module sram_block_lanes #(
  parameter int DATA_WIDTH     = 32,
  parameter int LANE_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 12,
  parameter int READ_LATENCY   = 1,
  parameter int RDW_NEW_DATA   = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_wr_en,
  input  logic [ADDR_WIDTH-1:0]            i_wr_addr,
  input  logic [DATA_WIDTH-1:0]            i_wr_data,
  input  logic [DATA_WIDTH/LANE_WIDTH-1:0] i_wr_lane,
  input  logic                             i_rd_en,
  input  logic [ADDR_WIDTH-1:0]            i_rd_addr,
  output logic [DATA_WIDTH-1:0]            o_rd_data,
  output logic                             o_rd_valid,
  input  logic                             i_clear,
  output logic                             o_ready
);

  localparam int LANES = DATA_WIDTH / LANE_WIDTH;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [1:0] ST_RESET = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

  logic [1:0]            state_reg, state_next;
  logic [ADDR_WIDTH-1:0] clr_cnt_reg, clr_cnt_next;
  logic                  clearing;
  logic                  clr_last;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  rdw_hit;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] s1_data;
  logic                  v1_reg;

  assign o_ready  = (state_reg == ST_IDLE);
  assign clearing = (state_reg == ST_CLEAR);
  assign clr_last = (clr_cnt_reg == {ADDR_WIDTH{1'b1}});
  assign wr_acc   = o_ready & i_wr_en;
  assign rd_acc   = o_ready & i_rd_en;
  assign rdw_hit  = (RDW_NEW_DATA != 0) && wr_acc && rd_acc && (i_wr_addr == i_rd_addr);
  assign mem_addr = clearing ? clr_cnt_reg : i_wr_addr;

  always_comb begin
    state_next   = state_reg;
    clr_cnt_next = clr_cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (i_clear) begin
          state_next   = ST_CLEAR;
          clr_cnt_next = '0;
        end
      end
      ST_CLEAR: begin
        clr_cnt_next = clr_cnt_reg + ADDR_WIDTH'(1);
        if (clr_last) state_next = ST_DONE;
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg   <= ST_RESET;
      clr_cnt_reg <= '0;
      v1_reg      <= 1'b0;
    end else begin
      state_reg   <= state_next;
      clr_cnt_reg <= clr_cnt_next;
      v1_reg      <= rd_acc;
    end
  end

  // One narrow RAM per lane so each lane enable maps onto its own write port.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : gen_lane
      logic [LANE_WIDTH-1:0] mem [DEPTH];
      logic [LANE_WIDTH-1:0] rd_q_reg;
      logic                  lane_we;
      logic [LANE_WIDTH-1:0] lane_wdata;

      assign lane_we    = clearing | (wr_acc & i_wr_lane[gi]);
      assign lane_wdata = clearing ? '0 : i_wr_data[gi*LANE_WIDTH +: LANE_WIDTH];

      always_ff @(posedge i_clk) begin
        if (lane_we) mem[mem_addr] <= lane_wdata;
        if (rd_acc)
          rd_q_reg <= (rdw_hit && i_wr_lane[gi]) ? i_wr_data[gi*LANE_WIDTH +: LANE_WIDTH]
                                                 : mem[i_rd_addr];
      end

      assign s1_data[gi*LANE_WIDTH +: LANE_WIDTH] = rd_q_reg;
    end
  endgenerate

  generate
    if (READ_LATENCY == 2) begin : gen_lat2
      logic [DATA_WIDTH-1:0] s2_data_reg;
      logic                  v2_reg;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          s2_data_reg <= '0;
          v2_reg      <= 1'b0;
        end else begin
          v2_reg <= v1_reg;
          if (v1_reg) s2_data_reg <= s1_data;
        end
      end

      assign o_rd_data  = s2_data_reg;
      assign o_rd_valid = v2_reg;
    end else begin : gen_lat1
      // RAM output register has no reset; mask it until the first read lands.
      logic any_rd_reg;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)    any_rd_reg <= 1'b0;
        else if (rd_acc) any_rd_reg <= 1'b1;
      end

      assign o_rd_data  = any_rd_reg ? s1_data : '0;
      assign o_rd_valid = v1_reg;
    end
  endgenerate

endmodule

// File: tb/tb_sram_block_lanes.sv
// Bench for sram_block_lanes: three configurations driven in lock-step, a reference
// memory model feeding per-instance scoreboards, plus directed value checks.
module tb_sram_block_lanes;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_wr_en;
  logic [3:0]  i_wr_addr;
  logic [31:0] i_wr_data;
  logic [3:0]  i_wr_lane;
  logic        i_rd_en;
  logic [3:0]  i_rd_addr;
  logic        i_clear;

  logic [2:0][31:0] rd_data;
  logic [2:0]       rd_valid;
  logic [2:0]       ready_o;

  int checks = 0;
  int errors = 0;

  exp_t        sb [3][$];
  logic [31:0] mdl_mem [16];
  int          low_cnt;
  int          cyc;

  // 0: latency 1 / old data, 1: latency 1 / new data, 2: latency 2 / old data
  sram_block_lanes #(.DATA_WIDTH(32), .LANE_WIDTH(8), .ADDR_WIDTH(4), .READ_LATENCY(1),
                     .RDW_NEW_DATA(0), .CLEAR_ON_RESET(1)) dut0 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr),
    .i_wr_data(i_wr_data), .i_wr_lane(i_wr_lane), .i_rd_en(i_rd_en), .i_rd_addr(i_rd_addr),
    .o_rd_data(rd_data[0]), .o_rd_valid(rd_valid[0]), .i_clear(i_clear), .o_ready(ready_o[0]));

  sram_block_lanes #(.DATA_WIDTH(32), .LANE_WIDTH(8), .ADDR_WIDTH(4), .READ_LATENCY(1),
                     .RDW_NEW_DATA(1), .CLEAR_ON_RESET(1)) dut1 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr),
    .i_wr_data(i_wr_data), .i_wr_lane(i_wr_lane), .i_rd_en(i_rd_en), .i_rd_addr(i_rd_addr),
    .o_rd_data(rd_data[1]), .o_rd_valid(rd_valid[1]), .i_clear(i_clear), .o_ready(ready_o[1]));

  sram_block_lanes #(.DATA_WIDTH(32), .LANE_WIDTH(8), .ADDR_WIDTH(4), .READ_LATENCY(2),
                     .RDW_NEW_DATA(0), .CLEAR_ON_RESET(1)) dut2 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr),
    .i_wr_data(i_wr_data), .i_wr_lane(i_wr_lane), .i_rd_en(i_rd_en), .i_rd_addr(i_rd_addr),
    .o_rd_data(rd_data[2]), .o_rd_valid(rd_valid[2]), .i_clear(i_clear), .o_ready(ready_o[2]));

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: acceptance, lane merge, clear timing; pushes expected reads.
  initial begin
    logic [31:0] old_w, mrg_w;
    cyc     = 0;
    low_cnt = 17;
    for (int a = 0; a < 16; a++) mdl_mem[a] = 32'h0;
    forever begin
      @(posedge i_clk or negedge i_rst_n);
      if (!i_rst_n) begin
        low_cnt = 17;
        for (int i = 0; i < 3; i++) sb[i].delete();
        for (int a = 0; a < 16; a++) mdl_mem[a] = 32'h0;
      end else begin
        cyc++;
        if (low_cnt == 0) begin
          if (i_rd_en) begin
            old_w = mdl_mem[i_rd_addr];
            mrg_w = old_w;
            if (i_wr_en && i_wr_addr == i_rd_addr)
              for (int k = 0; k < 4; k++)
                if (i_wr_lane[k]) mrg_w[k*8 +: 8] = i_wr_data[k*8 +: 8];
            sb[0].push_back('{old_w, cyc});
            sb[1].push_back('{mrg_w, cyc});
            sb[2].push_back('{old_w, cyc + 1});
          end
          if (i_wr_en)
            for (int k = 0; k < 4; k++)
              if (i_wr_lane[k]) mdl_mem[i_wr_addr][k*8 +: 8] = i_wr_data[k*8 +: 8];
          if (i_clear) begin
            low_cnt = 17;
            for (int a = 0; a < 16; a++) mdl_mem[a] = 32'h0;
          end
        end else begin
          low_cnt--;
        end
      end
    end
  end

  // Scoreboard monitor, sampled on the falling edge.
  initial begin
    exp_t e;
    bit   exp_v;
    forever begin
      @(negedge i_clk);
      for (int i = 0; i < 3; i++) begin
        exp_v = (sb[i].size() > 0) && (sb[i][0].cyc == cyc);
        chk($sformatf("valid%0d cyc%0d", i, cyc), {31'b0, rd_valid[i]}, {31'b0, exp_v});
        if (exp_v) begin
          e = sb[i].pop_front();
          chk($sformatf("data%0d cyc%0d", i, cyc), rd_data[i], e.data);
        end
        chk($sformatf("ready%0d cyc%0d", i, cyc), {31'b0, ready_o[i]},
            {31'b0, (low_cnt == 0)});
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic step(input bit wr, input logic [3:0] wa, input logic [31:0] wd,
                      input logic [3:0] wl, input bit rd, input logic [3:0] ra, input bit clr);
    i_wr_en   = wr;
    i_wr_addr = wa;
    i_wr_data = wd;
    i_wr_lane = wl;
    i_rd_en   = rd;
    i_rd_addr = ra;
    i_clear   = clr;
    @(posedge i_clk);
    #1;
    i_wr_en   = 1'b0;
    i_wr_addr = '0;
    i_wr_data = '0;
    i_wr_lane = '0;
    i_rd_en   = 1'b0;
    i_rd_addr = '0;
    i_clear   = 1'b0;
  endtask

  initial begin
    i_rst_n   = 1'b0;
    i_wr_en   = 1'b0;
    i_wr_addr = '0;
    i_wr_data = '0;
    i_wr_lane = '0;
    i_rd_en   = 1'b0;
    i_rd_addr = '0;
    i_clear   = 1'b0;
    idle(3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_data%0d", i), rd_data[i], 32'h0);
      chk($sformatf("reset_valid%0d", i), {31'b0, rd_valid[i]}, 32'h0);
      chk($sformatf("reset_ready%0d", i), {31'b0, ready_o[i]}, 32'h0);
    end
    i_rst_n = 1'b1;

    // Post-reset clear, then every address reads zero
    idle(16);
    chk("ready_low_16", {31'b0, ready_o[0]}, 32'h0);
    idle(1);
    chk("ready_after_17", {31'b0, ready_o[0]}, 32'h1);
    for (int a = 0; a < 16; a++) step(0, 0, 0, 0, 1, 4'(a), 0);
    idle(3);

    // Lane-masked overwrite, plus output hold
    step(1, 3, 32'hAABBCCDD, 4'b1111, 0, 0, 0);
    step(1, 3, 32'h11223344, 4'b0101, 0, 0, 0);
    step(0, 0, 0, 0, 1, 3, 0);
    chk("lane_merge", rd_data[0], 32'hAA22CC44);
    idle(2);
    chk("hold_data", rd_data[0], 32'hAA22CC44);

    // Same-address read during write
    step(1, 5, 32'hCAFEF00D, 4'b1111, 0, 0, 0);
    step(1, 5, 32'h12345678, 4'b0011, 1, 5, 0);
    chk("rdw_old", rd_data[0], 32'hCAFEF00D);
    chk("rdw_new", rd_data[1], 32'hCAFE5678);
    idle(1);
    chk("rdw_old_lat2", rd_data[2], 32'hCAFEF00D);
    idle(2);

    // Back-to-back reads, latency 2 ordering
    step(1, 0, 32'h10, 4'b1111, 0, 0, 0);
    step(1, 1, 32'h11, 4'b1111, 0, 0, 0);
    step(1, 2, 32'h12, 4'b1111, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 1, 0);
    chk("lat2_first", rd_data[2], 32'h10);
    step(0, 0, 0, 0, 1, 2, 0);
    chk("lat2_second", rd_data[2], 32'h11);
    idle(1);
    chk("lat2_third", rd_data[2], 32'h12);
    idle(2);

    // Requested clear ignores a write made while busy
    step(1, 7, 32'h00000077, 4'b1111, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    step(1, 7, 32'hFFFFFFFF, 4'b1111, 1, 7, 0);
    idle(15);
    chk("clear_ready_low", {31'b0, ready_o[0]}, 32'h0);
    idle(1);
    chk("clear_ready_high", {31'b0, ready_o[0]}, 32'h1);
    step(0, 0, 0, 0, 1, 7, 0);
    chk("clear_addr7", rd_data[0], 32'h0);
    idle(2);

    // Held clear request: repeated clears with one idle gap
    step(1, 9, 32'h99999999, 4'b1111, 0, 0, 0);
    i_clear = 1'b1;
    idle(40);
    i_clear = 1'b0;
    idle(20);
    step(0, 0, 0, 0, 1, 9, 0);
    idle(2);

    // Reset while a read is in flight
    step(1, 4, 32'h44444444, 4'b1111, 0, 0, 0);
    step(0, 0, 0, 0, 1, 4, 0);
    chk("inflight_valid", {31'b0, rd_valid[0]}, 32'h1);
    i_rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("async_valid%0d", i), {31'b0, rd_valid[i]}, 32'h0);
      chk($sformatf("async_data%0d", i), rd_data[i], 32'h0);
    end
    idle(2);
    i_rst_n = 1'b1;
    idle(17);
    chk("rst_read_ready", {31'b0, ready_o[0]}, 32'h1);

    // Reset part-way through a clear restarts it from address 0
    step(1, 12, 32'hC0C0C0C0, 4'b1111, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    idle(7);
    i_rst_n = 1'b0;
    #1;
    chk("midclear_ready", {31'b0, ready_o[0]}, 32'h0);
    idle(2);
    i_rst_n = 1'b1;
    idle(16);
    chk("restart_low", {31'b0, ready_o[0]}, 32'h0);
    idle(1);
    chk("restart_high", {31'b0, ready_o[0]}, 32'h1);
    step(0, 0, 0, 0, 1, 12, 0);
    chk("restart_addr12", rd_data[0], 32'h0);
    idle(3);

    for (int i = 0; i < 3; i++)
      chk($sformatf("sb_drained%0d", i), 32'(sb[i].size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
